// File: rtl/draw_health_bar_pkg.sv
// health_pkg: shared types and constants for the health HUD.
//   health_state_t : player health FSM states
//   vga_t          : one pixel of VGA timing + colour, packed (38 bits)
//   KEY_COLOUR     : icon ROM colour treated as transparent
//   BLANK_COLOUR   : colour forced during blanking
// Optional: HEALTH_GHOST_ICONS_EN adds dim_rgb() for lost-heart icons.
package health_pkg;

  typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} health_state_t;

  localparam logic [11:0] KEY_COLOUR   = 12'h000;
  localparam logic [11:0] BLANK_COLOUR = 12'h888;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  localparam int VGA_W = $bits(vga_t);

`ifdef HEALTH_GHOST_ICONS_EN
  // Halve each 4-bit channel.
  function automatic logic [11:0] dim_rgb(input logic [11:0] c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction
`endif

endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing + colour bundle passed along the draw chain.
//   modport in  : consumer side
//   modport out : producer side
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/delay.sv
// delay: fixed-latency register pipeline.
//   clk, rst : clock, synchronous active-high reset (clears all stages)
//   din      : WIDTH-bit input
//   dout     : din delayed by CLK_DEL clocks
module delay #(
  parameter int WIDTH   = 38,
  parameter int CLK_DEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [CLK_DEL-1:0][WIDTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_health_bar_fsm.sv
// health_fsm: player health, damage/heal handling, invulnerability window.
//   clk, rst   : clock, synchronous active-high reset
//   start_game : level, low forces IDLE
//   hit, heal  : single-cycle requests
//   frame_tick : one pulse per frame, paces the blink window
//   health     : current health
//   dead       : high in DEAD
//   visible    : icons shown this cycle (blink gating)
//   state      : current FSM state
module health_fsm
  import health_pkg::*;
#(
  parameter int MAX_HEALTH   = 5,
  parameter int INIT_HEALTH  = 3,
  parameter int BLINK_FRAMES = 90,
  parameter int BLINK_LOG2   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_game,
  input  logic          hit,
  input  logic          heal,
  input  logic          frame_tick,
  output logic [3:0]    health,
  output logic          dead,
  output logic          visible,
  output health_state_t state
);

  // Counter must hold BLINK_FRAMES and also own the blink bit.
  localparam int CW  = $clog2(BLINK_FRAMES + 1);
  localparam int BW  = (CW > BLINK_LOG2 + 1) ? CW : BLINK_LOG2 + 1;
  localparam logic [3:0]    MAX_H   = 4'(MAX_HEALTH);
  localparam logic [3:0]    INIT_H  = 4'(INIT_HEALTH);
  localparam logic [BW-1:0] BLINK_N = BW'(BLINK_FRAMES);

  health_state_t state_q;
  logic [3:0]    health_q;
  logic [BW-1:0] blink_q;
  logic          dead_q;
  logic [3:0]    healed;

  assign healed = (health_q == MAX_H) ? health_q : health_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      health_q <= '0;
      blink_q  <= '0;
      dead_q   <= 1'b0;
    end else if (!start_game) begin
      // Game stopped: health is kept for display until the next start.
      state_q <= IDLE;
      blink_q <= '0;
      dead_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q  <= ALIVE;
          health_q <= INIT_H;
        end
        ALIVE: begin
          if (hit) begin
            health_q <= health_q - 4'd1;
            if (health_q == 4'd1) begin
              state_q <= DEAD;
              dead_q  <= 1'b1;
            end else begin
              state_q <= INVULN;
              blink_q <= BLINK_N;
            end
          end else if (heal) begin
            health_q <= healed;
          end
        end
        INVULN: begin
          if (heal) health_q <= healed;
          if (frame_tick) begin
            blink_q <= blink_q - 1'b1;
            if (blink_q == BW'(1)) state_q <= ALIVE;
          end
        end
        DEAD: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign health  = health_q;
  assign dead    = dead_q;
  assign state   = state_q;
  assign visible = (state_q == ALIVE) || ((state_q == INVULN) && !blink_q[BLINK_LOG2]);

endmodule

// File: rtl/draw_health_bar.sv
// draw_health_bar: HUD layer drawing up to MAX_HEALTH heart icons.
//   clk, rst    : pixel clock, synchronous active-high reset
//   start_game  : level, game running
//   en          : draw enable (health logic runs regardless)
//   hit, heal   : single-cycle damage / heal requests
//   rgb_pixel   : icon ROM data, 1 clk after pixel_addr
//   pixel_addr  : icon ROM address {row, col}
//   health,dead : player status
//   in, out     : VGA stream, out = in delayed 3 clk with icons overlaid
// Optional: define HEALTH_GHOST_ICONS_EN to draw lost hearts dimmed.
module draw_health_bar
  import health_pkg::*;
#(
  parameter int XPOS         = 800,
  parameter int YPOS         = 16,
  parameter int ICON_LOG2    = 6,
  parameter int MAX_HEALTH   = 5,
  parameter int INIT_HEALTH  = 3,
  parameter int BLINK_FRAMES = 90,
  parameter int BLINK_LOG2   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_game,
  input  logic                   en,
  input  logic                   hit,
  input  logic                   heal,
  input  logic [11:0]            rgb_pixel,
  output logic [2*ICON_LOG2-1:0] pixel_addr,
  output logic [3:0]             health,
  output logic                   dead,
  vga_if.in                      in,
  vga_if.out                     out
);

  localparam logic [10:0] X_LO = 11'(XPOS);
  localparam logic [10:0] X_HI = 11'(XPOS + (MAX_HEALTH << ICON_LOG2));
  localparam logic [10:0] Y_LO = 11'(YPOS);
  localparam logic [10:0] Y_HI = 11'(YPOS + (1 << ICON_LOG2));

  // Geometry on the raw input pixel
  logic [10:0]          hrel;
  logic [ICON_LOG2-1:0] vrel_lo;
  logic                 in_slot;
  logic [3:0]           slot;

  assign hrel    = in.hcount - X_LO;
  assign vrel_lo = ICON_LOG2'(in.vcount - Y_LO);
  assign in_slot = (in.vcount >= Y_LO) && (in.vcount < Y_HI) &&
                   (in.hcount >= X_LO) && (in.hcount < X_HI);
  assign slot    = 4'(hrel >> ICON_LOG2);

  // Slot info travels alongside the ROM access (stages 1 and 2)
  logic       in_slot_q1, in_slot_q2;
  logic [3:0] slot_q1, slot_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr <= '0;
      in_slot_q1 <= 1'b0;
      in_slot_q2 <= 1'b0;
      slot_q1    <= '0;
      slot_q2    <= '0;
    end else begin
      if (in_slot) pixel_addr <= {vrel_lo, hrel[ICON_LOG2-1:0]};
      in_slot_q1 <= in_slot;
      slot_q1    <= slot;
      in_slot_q2 <= in_slot_q1;
      slot_q2    <= slot_q1;
    end
  end

  // Frame tick on vblnk rising edge
  logic vblnk_q, frame_tick;

  always_ff @(posedge clk) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= in.vblnk;
  end

  assign frame_tick = in.vblnk && !vblnk_q;

  health_state_t state;
  logic          visible;

  health_fsm #(
    .MAX_HEALTH  (MAX_HEALTH),
    .INIT_HEALTH (INIT_HEALTH),
    .BLINK_FRAMES(BLINK_FRAMES),
    .BLINK_LOG2  (BLINK_LOG2)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start_game(start_game),
    .hit       (hit),
    .heal      (heal),
    .frame_tick(frame_tick),
    .health    (health),
    .dead      (dead),
    .visible   (visible),
    .state     (state)
  );

  // Timing + incoming colour delayed to line up with rgb_pixel
  vga_t pix_in, pix_dly, out_q;

  assign pix_in = '{vcount: in.vcount, vsync: in.vsync, vblnk: in.vblnk,
                    hcount: in.hcount, hsync: in.hsync, hblnk: in.hblnk,
                    rgb: in.rgb};

  delay #(.WIDTH(VGA_W), .CLK_DEL(2)) u_delay (
    .clk (clk),
    .rst (rst),
    .din (pix_in),
    .dout(pix_dly)
  );

  logic [11:0] rgb_d;

  always_comb begin
    rgb_d = pix_dly.rgb;
    if (pix_dly.vblnk || pix_dly.hblnk) begin
      rgb_d = BLANK_COLOUR;
    end else if (en && (state != IDLE) && in_slot_q2 && visible &&
                 (rgb_pixel != KEY_COLOUR)) begin
      if (slot_q2 < health) rgb_d = rgb_pixel;
`ifdef HEALTH_GHOST_ICONS_EN
      else                  rgb_d = dim_rgb(rgb_pixel);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q     <= pix_dly;
      out_q.rgb <= rgb_d;
    end
  end

  assign out.vcount = out_q.vcount;
  assign out.vsync  = out_q.vsync;
  assign out.vblnk  = out_q.vblnk;
  assign out.hcount = out_q.hcount;
  assign out.hsync  = out_q.hsync;
  assign out.hblnk  = out_q.hblnk;
  assign out.rgb    = out_q.rgb;

endmodule
